i2s: RTL and testbench

- Stereo 16-bit I2S (Philips format) serializer for the audio DAC, in the MasterCLK domain.
- Takes a free-running bit-clock reference (I2SCLK, about 44.1 kHz x 32) from the clock manager as a data input, synchronizes it, and re-emits it as I2S_CLK with aligned I2S_WS and I2S_DATA.
- Emits SyncCLK once per frame so the upstream mixer can present the next sample on InputData.

---
 rtl/audvid_pkg.sv | 21 ++
 rtl/i2s_clk_sync.sv | 45 ++++
 rtl/i2s.sv | 109 ++++++++++
 tb/tb_i2s.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/audvid_pkg.sv
// Shared audio/video constants and payload types.
// Holds the I2S frame geometry, the slot numbers that matter to the
// serializer, and the stereo sample layout presented by the mixer.
package audvid_pkg;

  localparam int unsigned CHANNEL_BITS  = 16;
  localparam int unsigned FRAME_SLOTS   = 2 * CHANNEL_BITS;
  localparam int unsigned SLOT_W        = $clog2(FRAME_SLOTS);

  // Slot entered on the fall that loads the next sample (left MSB goes out).
  localparam int unsigned SLOT_LOAD     = 1;
  // First slot with word select high (right channel, one slot ahead of its MSB).
  localparam int unsigned SLOT_WS_RIGHT = 16;

  // Stereo sample as carried on InputData: left in the upper half.
  typedef struct packed {
    logic signed [CHANNEL_BITS-1:0] left;
    logic signed [CHANNEL_BITS-1:0] right;
  } stereo_t;

endpackage

// File: rtl/i2s_clk_sync.sv
// Brings the asynchronous bit-clock reference into the MasterCLK domain
// and flags its edges.
//   clk_i     system clock
//   rst_i     asynchronous active-high reset
//   async_i   bit-clock reference (data, not a clock)
//   sync_o    synchronized level (registered)
//   rise_c_o  combinational: synchronized level went 0 -> 1 this cycle
//   fall_c_o  combinational: synchronized level went 1 -> 0 this cycle
module i2s_clk_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  import audvid_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  // Shift chain: bit 0 is the metastability-exposed stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o   = sync_q[SYNC_STAGES-1];
  assign rise_c_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2s.sv
// Stereo Philips-format I2S serializer for the audio DAC.
// Re-times the bit-clock reference into MasterCLK and emits bit clock,
// word select and MSB-first data, all changing on the bit-clock fall.
//   MasterCLK  system clock, the only clock in the block
//   Reset      asynchronous active-high reset
//   I2SCLK     bit-clock reference, sampled as data
//   InputData  stereo sample, [2W-1:W] left, [W-1:0] right
//   I2S_CLK    serial bit clock (registered)
//   I2S_WS     word select, 0 = left, 1 = right (registered)
//   I2S_DATA   serial data, MSB first (registered)
//   SyncCLK    high for the left half of the frame; rising edge asks for
//              the next sample (registered)
module i2s #(
  parameter int unsigned CHANNEL_BITS = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                      MasterCLK,
  input  logic                      Reset,
  input  logic                      I2SCLK,
  input  logic [2*CHANNEL_BITS-1:0] InputData,
  output logic                      I2S_CLK,
  output logic                      I2S_WS,
  output logic                      I2S_DATA,
  output logic                      SyncCLK
);

  import audvid_pkg::*;

  localparam int unsigned FRAME_W = 2 * CHANNEL_BITS;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] SLOT_FIRST = CNT_W'(SLOT_LOAD);
  localparam logic [CNT_W-1:0] SLOT_RIGHT = CNT_W'(CHANNEL_BITS);

  logic bclk_s;
  logic bclk_rise_c;
  logic bclk_fall_c;

  logic               clk_q,   clk_d;
  logic               ws_q,    ws_d;
  logic               data_q,  data_d;
  logic               frm_q,   frm_d;
  logic [CNT_W-1:0]   slot_q,  slot_d;
  logic [FRAME_W-1:0] shift_q, shift_d;

  i2s_clk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_clk_sync (
    .clk_i    (MasterCLK),
    .rst_i    (Reset),
    .async_i  (I2SCLK),
    .sync_o   (bclk_s),
    .rise_c_o (bclk_rise_c),
    .fall_c_o (bclk_fall_c)
  );

  // Slot advance and serialization; everything but the bit clock moves
  // only on a detected fall so data is settled a half period before the
  // DAC samples on the next rise.
  always_comb begin
    clk_d   = bclk_s;
    ws_d    = ws_q;
    data_d  = data_q;
    frm_d   = frm_q;
    slot_d  = slot_q;
    shift_d = shift_q;

    if (bclk_fall_c) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + CNT_W'(1);

      // Word select leads each channel MSB by one slot (Philips delay).
      ws_d  = (slot_d >= SLOT_RIGHT);
      frm_d = (slot_d < SLOT_RIGHT);

      if (slot_d == SLOT_FIRST) begin
        shift_d = InputData;
      end else begin
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
      end
      data_d = shift_d[FRAME_W-1];
    end
  end

  // Reset parks the counter on the last slot so the first fall enters slot 0.
  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) begin
      clk_q   <= 1'b0;
      ws_q    <= 1'b0;
      data_q  <= 1'b0;
      frm_q   <= 1'b0;
      slot_q  <= SLOT_LAST;
      shift_q <= '0;
    end else begin
      clk_q   <= clk_d;
      ws_q    <= ws_d;
      data_q  <= data_d;
      frm_q   <= frm_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
    end
  end

  assign I2S_CLK  = clk_q;
  assign I2S_WS   = ws_q;
  assign I2S_DATA = data_q;
  assign SyncCLK  = frm_q;

endmodule

// File: tb/tb_i2s.sv
// Directed bench for the I2S serializer: idle after reset, bit-clock
// latency, frame contents for several words, sample handoff isolation,
// frame strobe alignment, and mid-frame asynchronous reset.
module tb_i2s;

  import audvid_pkg::*;

  logic        MasterCLK = 1'b0;
  logic        Reset;
  logic        I2SCLK = 1'b0;
  logic [31:0] InputData;
  logic        I2S_CLK;
  logic        I2S_WS;
  logic        I2S_DATA;
  logic        SyncCLK;

  int n_cmp = 0;
  int n_err = 0;

  always #5 MasterCLK = ~MasterCLK;

  i2s #(
    .CHANNEL_BITS(16),
    .SYNC_STAGES (2)
  ) dut (
    .MasterCLK (MasterCLK),
    .Reset     (Reset),
    .I2SCLK    (I2SCLK),
    .InputData (InputData),
    .I2S_CLK   (I2S_CLK),
    .I2S_WS    (I2S_WS),
    .I2S_DATA  (I2S_DATA),
    .SyncCLK   (SyncCLK)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-clock reference: 38 MasterCLK cycles per half period (760 ns period).
  bit run_clk = 1'b0;
  int gen_cnt = 0;
  always @(negedge MasterCLK) begin
    if (run_clk) begin
      if (gen_cnt == 37) begin
        I2SCLK  = ~I2SCLK;
        gen_cnt = 0;
      end else begin
        gen_cnt++;
      end
    end
  end

  // Output watcher: WS/DATA/SyncCLK may only move on the cycle I2S_CLK falls.
  bit   mon_en = 1'b0;
  int   viol = 0;
  int   sync_rises = 0;
  time  t_sync_rise = 0;
  time  t_ws_fall = 0;
  logic pclk = 1'b0, pws = 1'b0, pdata = 1'b0, psync = 1'b0;
  logic fell;
  always @(posedge MasterCLK) begin
    #1;
    fell = pclk & ~I2S_CLK;
    if (mon_en) begin
      if ((I2S_WS !== pws || I2S_DATA !== pdata || SyncCLK !== psync) && !fell) viol++;
      if (!psync && SyncCLK) begin
        sync_rises++;
        t_sync_rise = $time;
      end
      if (pws && !I2S_WS) t_ws_fall = $time;
    end
    pclk  = I2S_CLK;
    pws   = I2S_WS;
    pdata = I2S_DATA;
    psync = SyncCLK;
  end

  // Wait for the next I2S_CLK fall and return the slot outputs it set.
  task automatic get_slot(output logic ws, output logic data, output logic sy);
    logic pc;
    bit   found;
    found = 1'b0;
    ws = 1'b0; data = 1'b0; sy = 1'b0;
    @(negedge MasterCLK);
    pc = I2S_CLK;
    for (int i = 0; i < 400; i++) begin
      @(negedge MasterCLK);
      if (pc && !I2S_CLK) begin
        ws    = I2S_WS;
        data  = I2S_DATA;
        sy    = SyncCLK;
        found = 1'b1;
        break;
      end
      pc = I2S_CLK;
    end
    check_eq("slot_found", 32'(found), 32'd1);
  endtask

  // Called while sitting in slot 0: present word, capture slots 1..31 and
  // the following slot 0. ser is the serialized word, MSB first.
  task automatic run_frame(input logic [31:0] word, input bit inject, input logic [31:0] junk,
                           output logic [31:0] ser, output logic [31:0] wsv, output logic [31:0] syv);
    logic w, d, y;
    int   r0;
    r0 = sync_rises;
    ser = '0; wsv = '0; syv = '0;
    InputData = word;
    for (int s = 1; s <= 32; s++) begin
      get_slot(w, d, y);
      ser[(32 - s) % 32] = d;
      wsv[s % 32]        = w;
      syv[s % 32]        = y;
      if (inject && s == 10) InputData = junk;
    end
    check_eq("sync_rise_per_frame", 32'(sync_rises - r0), 32'd1);
    check_eq("sync_ws_align", 32'(t_sync_rise == t_ws_fall), 32'd1);
  endtask

  logic [31:0] ser, wsv, syv;
  logic        w, d, y;
  int          lat;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    InputData = '0;
    repeat (3) @(negedge MasterCLK);
    check_eq("rst_clk",  32'(I2S_CLK),  32'd0);
    check_eq("rst_ws",   32'(I2S_WS),   32'd0);
    check_eq("rst_data", 32'(I2S_DATA), 32'd0);
    check_eq("rst_sync", 32'(SyncCLK),  32'd0);

    Reset  = 1'b0;
    mon_en = 1'b1;
    repeat (200) @(negedge MasterCLK);
    check_eq("idle_clk",  32'(I2S_CLK),  32'd0);
    check_eq("idle_ws",   32'(I2S_WS),   32'd0);
    check_eq("idle_data", 32'(I2S_DATA), 32'd0);
    check_eq("idle_sync", 32'(SyncCLK),  32'd0);

    // Bit clock latency: three MasterCLK edges from reference rise.
    InputData = 32'hA5A5_0F0F;
    run_clk   = 1'b1;
    @(posedge I2SCLK);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge MasterCLK);
      #1;
      lat++;
      if (I2S_CLK) break;
    end
    check_eq("latency", 32'(lat), 32'd3);

    // First fall enters slot 0 with empty shifter.
    get_slot(w, d, y);
    check_eq("s0_data", 32'(d), 32'd0);
    check_eq("s0_ws",   32'(w), 32'd0);
    check_eq("s0_sync", 32'(y), 32'd1);

    run_frame(32'hA5A5_0F0F, 1'b0, 32'h0, ser, wsv, syv);
    check_eq("frame_a5a5",  ser, 32'hA5A5_0F0F);
    check_eq("ws_map",      wsv, 32'hFFFF_0000);
    check_eq("sync_map",    syv, 32'h0000_FFFF);
    check_eq("right_lsb",   32'(ser[0]), 32'd1);

    run_frame(32'h7FFF_8000, 1'b0, 32'h0, ser, wsv, syv);
    check_eq("frame_7fff", ser, 32'h7FFF_8000);

    run_frame(32'h0001_FFFF, 1'b1, 32'hDEAD_BEEF, ser, wsv, syv);
    check_eq("frame_0001_inj", ser, 32'h0001_FFFF);

    run_frame(32'h7FFF_8000, 1'b1, 32'h1234_5678, ser, wsv, syv);
    check_eq("frame_7fff_inj", ser, 32'h7FFF_8000);
    check_eq("ws_map2",        wsv, 32'hFFFF_0000);

    // Advance to slot 20 with an all-ones word, then reset while I2S_CLK is high.
    InputData = 32'hFFFF_FFFF;
    for (int s = 1; s <= 20; s++) get_slot(w, d, y);
    check_eq("s20_ws",   32'(w), 32'd1);
    check_eq("s20_sync", 32'(y), 32'd0);
    check_eq("s20_data", 32'(d), 32'd1);
    repeat (50) @(negedge MasterCLK);
    check_eq("s20_clk_hi", 32'(I2S_CLK), 32'd1);

    mon_en = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check_eq("async_clk",  32'(I2S_CLK),  32'd0);
    check_eq("async_ws",   32'(I2S_WS),   32'd0);
    check_eq("async_data", 32'(I2S_DATA), 32'd0);
    check_eq("async_sync", 32'(SyncCLK),  32'd0);
    #47;
    Reset = 1'b0;
    @(negedge MasterCLK);
    mon_en = 1'b1;

    // Framing restarts at slot 0; first loaded word comes out from slot 1.
    InputData = 32'hC3A5_5A3C;
    get_slot(w, d, y);
    check_eq("post_s0_data", 32'(d), 32'd0);
    check_eq("post_s0_ws",   32'(w), 32'd0);
    check_eq("post_s0_sync", 32'(y), 32'd1);
    run_frame(32'hC3A5_5A3C, 1'b0, 32'h0, ser, wsv, syv);
    check_eq("post_frame", ser, 32'hC3A5_5A3C);
    check_eq("post_ws_map", wsv, 32'hFFFF_0000);

    check_eq("fall_only_changes", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
